// File: rtl/instr_queue.sv
// instr_queue: 2-wide instruction buffer between fetch and dispatch.
// Holds DEPTH {pc, instr} entries in a circular buffer. Fetch pairs are
// written two at a time, and the two oldest entries are shown at the
// head. Fetch is stalled whenever a full pair might not fit.
module instr_queue #(
  parameter int DEPTH = 8,
  parameter int PCW   = 4,
  parameter int IW    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_valid,
  input  logic [PCW-1:0]           pc1,
  input  logic [PCW-1:0]           pc2,
  input  logic [IW-1:0]            instr1,
  input  logic [IW-1:0]            instr2,
  input  logic                     flush,
  input  logic [1:0]               deq_count,
  output logic                     stall,
  output logic                     out_valid0,
  output logic [PCW-1:0]           out_pc0,
  output logic [IW-1:0]            out_instr0,
  output logic                     out_valid1,
  output logic [PCW-1:0]           out_pc1,
  output logic [IW-1:0]            out_instr1,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Entry storage. It has no reset because the pointers and count define
  // which entries are live.
  logic [PCW-1:0] pc_mem    [DEPTH];
  logic [IW-1:0]  instr_mem [DEPTH];

  logic [AW-1:0]  head;
  logic [AW-1:0]  tail;
  logic [CW-1:0]  cnt;

  logic [AW-1:0]  head_nx1;
  logic [AW-1:0]  tail_nx1;
  logic           enq;
  logic [1:0]     deq_sat;
  logic [CW-1:0]  eff_deq;
  logic [CW-1:0]  cnt_next;

  // Dequeue request clamped to 2, then to the occupancy. Stall is taken
  // from the current count only, so deq_count never feeds into it.
  always_comb begin
    head_nx1 = head + AW'(1);
    tail_nx1 = tail + AW'(1);
    stall    = (cnt > CW'(DEPTH - 2));
    enq      = fetch_valid && !stall && !flush;
    deq_sat  = (deq_count == 2'd3) ? 2'd2 : deq_count;
    eff_deq  = (CW'(deq_sat) > cnt) ? cnt : CW'(deq_sat);
    cnt_next = cnt + (enq ? CW'(2) : CW'(0)) - eff_deq;
  end

  // Pointer and count state. Reset takes priority over flush, and flush
  // takes priority over any enqueue or dequeue in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + eff_deq[AW-1:0];
      if (enq) tail <= tail + AW'(2);
      cnt  <= cnt_next;
    end
  end

  // Pair write. The older instruction goes to tail and the younger one
  // to tail+1.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[tail]        <= pc1;
      instr_mem[tail]     <= instr1;
      pc_mem[tail_nx1]    <= pc2;
      instr_mem[tail_nx1] <= instr2;
    end
  end

  // Zero-latency head read. The output fields are forced to 0 when their
  // valid bit is low.
  always_comb begin
    out_valid0 = (cnt >= CW'(1));
    out_valid1 = (cnt >= CW'(2));
    out_pc0    = out_valid0 ? pc_mem[head]        : '0;
    out_instr0 = out_valid0 ? instr_mem[head]     : '0;
    out_pc1    = out_valid1 ? pc_mem[head_nx1]    : '0;
    out_instr1 = out_valid1 ? instr_mem[head_nx1] : '0;
    count      = cnt;
  end

  // Occupancy can never pass DEPTH. A pair is only accepted at DEPTH-2
  // or below.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) cnt <= CW'(DEPTH));

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: directed and random stimulus checked against a queue model
// of instr_queue.
module tb_instr_queue;

  localparam int DEPTH = 8;
  localparam int PCW   = 4;
  localparam int IW    = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            fetch_valid;
  logic [PCW-1:0]  pc1, pc2;
  logic [IW-1:0]   instr1, instr2;
  logic            flush;
  logic [1:0]      deq_count;
  logic            stall;
  logic            out_valid0, out_valid1;
  logic [PCW-1:0]  out_pc0, out_pc1;
  logic [IW-1:0]   out_instr0, out_instr1;
  logic [3:0]      count;

  instr_queue #(.DEPTH(DEPTH), .PCW(PCW), .IW(IW)) dut (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid),
    .pc1(pc1), .pc2(pc2), .instr1(instr1), .instr2(instr2),
    .flush(flush), .deq_count(deq_count), .stall(stall),
    .out_valid0(out_valid0), .out_pc0(out_pc0), .out_instr0(out_instr0),
    .out_valid1(out_valid1), .out_pc1(out_pc1), .out_instr1(out_instr1),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PCW-1:0] pc;
    logic [IW-1:0]  ins;
  } ent_t;

  ent_t           q[$];
  int             nvec = 0;
  int             nerr = 0;
  logic           acc;
  logic [PCW-1:0] fpc;
  logic [PCW-1:0] pc_tmp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Put the current fetch pair from fpc on the inputs.
  task automatic present(input logic rnd_instr);
    pc1    = fpc;
    pc2    = fpc + 4'd1;
    instr1 = rnd_instr ? IW'($urandom) : {12'hA00, fpc};
    instr2 = rnd_instr ? IW'($urandom) : {12'hA00, pc2};
  endtask

  // One clock. Check stall before the edge, update the model, then check
  // all outputs just after the edge.
  task automatic step();
    int   n;
    int   d;
    logic stall_pre;
    n         = q.size();
    stall_pre = (n > DEPTH - 2);
    chk("stall_pre", {31'b0, stall}, {31'b0, stall_pre});
    acc = 1'b0;
    if (reset || flush) begin
      q.delete();
    end else begin
      d = (deq_count == 2'd3) ? 2 : int'(deq_count);
      if (d > n) d = n;
      repeat (d) void'(q.pop_front());
      if (fetch_valid && !stall_pre) begin
        acc = 1'b1;
        q.push_back({pc1, instr1});
        q.push_back({pc2, instr2});
      end
    end
    @(posedge clk);
    #1;
    n = q.size();
    chk("count", {28'b0, count}, n);
    chk("stall", {31'b0, stall}, (n > DEPTH - 2) ? 1 : 0);
    chk("valid0", {31'b0, out_valid0}, (n >= 1) ? 1 : 0);
    chk("valid1", {31'b0, out_valid1}, (n >= 2) ? 1 : 0);
    chk("pc0", {28'b0, out_pc0}, (n >= 1) ? {28'b0, q[0].pc} : 0);
    chk("instr0", {16'b0, out_instr0}, (n >= 1) ? {16'b0, q[0].ins} : 0);
    chk("pc1", {28'b0, out_pc1}, (n >= 2) ? {28'b0, q[1].pc} : 0);
    chk("instr1", {16'b0, out_instr1}, (n >= 2) ? {16'b0, q[1].ins} : 0);
  endtask

  // Fetch side: a pair moves on only after it has been accepted.
  task automatic fstep(input logic fv, input logic [1:0] dq);
    fetch_valid = fv;
    deq_count   = dq;
    present(1'b0);
    step();
    if (acc) fpc = fpc + 4'd2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; fetch_valid = 1'b0; deq_count = 2'd0;
    fpc = '0;
    present(1'b0);
    step();
    step();
    reset = 1'b0;

    // Test 1: first pair becomes visible one edge after it is written.
    fstep(1'b1, 2'd0);
    chk("t1_count", {28'b0, count}, 2);
    chk("t1_pc1", {28'b0, out_pc1}, 1);
    chk("t1_instr0", {16'b0, out_instr0}, 32'hA000);

    // Test 2: fill to DEPTH. Pair 8/9 is held while stall is high.
    fstep(1'b1, 2'd0);
    fstep(1'b1, 2'd0);
    fstep(1'b1, 2'd0);
    chk("t2_full", {28'b0, count}, 8);
    fstep(1'b1, 2'd0);
    chk("t2_held", {28'b0, count}, 8);

    // Test 3: drain two while stalled, then the held pair is written.
    fstep(1'b1, 2'd2);
    chk("t3_count", {28'b0, count}, 6);
    chk("t3_pc0", {28'b0, out_pc0}, 2);
    fstep(1'b1, 2'd2);
    chk("t3_count2", {28'b0, count}, 6);

    // Test 4: steady state across pointer and PC wrap.
    pc_tmp = out_pc0;
    for (int i = 0; i < 20; i++) begin
      fstep(1'b1, 2'd2);
      pc_tmp = pc_tmp + 4'd2;
      chk("t4_seq", {28'b0, out_pc0}, {28'b0, pc_tmp});
    end

    // Test 5: over-request at count 1, then deq_count=3 clamps to 2.
    fstep(1'b0, 2'd1);
    fstep(1'b0, 2'd2);
    fstep(1'b0, 2'd2);
    chk("t5_one", {28'b0, count}, 1);
    fstep(1'b0, 2'd2);
    chk("t5_empty", {28'b0, count}, 0);
    fstep(1'b1, 2'd0);
    fstep(1'b1, 2'd0);
    fstep(1'b0, 2'd3);
    chk("t5_deq3", {28'b0, count}, 2);

    // Test 6: flush at count 5 overrides enqueue and dequeue.
    fstep(1'b1, 2'd0);
    fstep(1'b1, 2'd1);
    chk("t6_five", {28'b0, count}, 5);
    flush = 1'b1;
    fstep(1'b1, 2'd2);
    flush = 1'b0;
    chk("t6_flush", {28'b0, count}, 0);
    fstep(1'b1, 2'd0);
    fstep(1'b1, 2'd0);
    fstep(1'b1, 2'd0);
    reset = 1'b1;
    fstep(1'b1, 2'd2);
    reset = 1'b0;
    chk("t6_reset", {28'b0, count}, 0);

    // Random phase: fetch, dequeue, flush and reset all mixed.
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(63) == 0);
      flush       = ($urandom_range(31) == 0);
      fetch_valid = ($urandom_range(3) != 0);
      deq_count   = 2'($urandom);
      present(1'b1);
      step();
      if (reset || flush) fpc = PCW'($urandom);
      else if (acc) fpc = fpc + 4'd2;
    end
    reset = 1'b0; flush = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Dual-entry-wide instruction buffer directly downstream of the 2-wide fetch stage.
- Each cycle it accepts the fetch pair (pc1/pc2 plus their instruction words from instruction memory).
- It presents the two oldest entries in program order to dispatch/issue.
- It drives `stall` back to fetch when there is no room for a full pair; stalled fetch holds pc1/pc2, so the same pair is re-presented.

Parameters:
- DEPTH, 8, number of entries; power of 2, >= 4.
- PCW, 4, PC width; matches fetch pc1/pc2 width.
- IW, 16, instruction word width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- fetch_valid  in  1  pc1/pc2/instr1/instr2 carry a valid fetch pair this cycle.
- pc1  in  PCW  PC of older fetched instruction.
- pc2  in  PCW  PC of younger fetched instruction.
- instr1  in  IW  instruction word at pc1.
- instr2  in  IW  instruction word at pc2.
- flush  in  1  discard all queued entries (redirect/mispredict).
- deq_count  in  2  entries consumed by dispatch this cycle (0, 1 or 2).
- stall  out  1  to fetch; high = pair not accepted this cycle.
- out_valid0  out  1  head entry valid.
- out_pc0  out  PCW  head entry PC.
- out_instr0  out  IW  head entry instruction.
- out_valid1  out  1  head+1 entry valid.
- out_pc1  out  PCW  head+1 entry PC.
- out_instr1  out  IW  head+1 entry instruction.
- count  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.

Behaviour:
- **Storage:** circular buffer of DEPTH {pc, instr}.
  - head/tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is held as a separate register.
- **Reset:** head=tail=count=0; stall=0; out_valid0/1=0; all out_pc/out_instr=0.
  - Reset has priority over flush and all other inputs.
  - Reset mid-operation discards all contents.
- **stall:** combinational, `stall = (count > DEPTH-2)`.
  - It is evaluated on the current count, before this cycle's dequeue (conservative; no combinational path from deq_count).
- **Enqueue:** enq = fetch_valid && !stall && !flush.
  - Always 2 entries: instr1/pc1 at tail, instr2/pc2 at tail+1.
  - tail += 2.
  - No partial (single-entry) enqueue.
- **Dequeue:** eff_deq = min(deq_count, count); deq_count=3 is treated as 2.
  - head += eff_deq.
  - Requesting more than valid is never an error, only clamped.
- **Count update:** count_next = count + (enq ? 2 : 0) - eff_deq.
  - Enqueue and dequeue in the same cycle both take effect.
  - Entries written this cycle are not dequeued this cycle.
- **Outputs:** combinational from head (zero-latency read).
  - out_valid0 = (count >= 1); out_valid1 = (count >= 2).
  - out_pc/out_instr are driven 0 when the matching valid is 0.
- **Latency:** a pair enqueued at edge N is visible on the outputs after edge N (one-cycle fill latency into an empty queue).
- **Ordering:** strict program order; entry at pc1 is always older than pc2. PCW wrap-around (e.g. 14,15,0,1) is passed through unmodified.
- **flush (no reset):** head=tail=count=0 next cycle.
  - Same-cycle enqueue and dequeue are ignored.
  - stall is evaluated on the pre-flush count during the flush cycle.
- **Full boundary:** count=DEPTH is reachable only via the final accepted pair (from DEPTH-2).
  - Overflow is impossible by construction.
  - Assertion: count never exceeds DEPTH.
- **Empty boundary:** count=0 gives both valids low; deq_count is ignored.

Test Plan:
1. Reset; fetch_valid=1, pc1=0/pc2=1, instr1=0xA000/instr2=0xA001, deq_count=0, one clk -> count=2, out_valid0=1 out_pc0=0 out_instr0=0xA000, out_valid1=1 out_pc1=1 out_instr1=0xA001, stall=0.
2. Enqueue 4 consecutive pairs (pcs 0..7), deq_count=0 -> count 2,4,6,8; stall=0 through count=6; stall=1 at count=8; the 5th pair (pc 8/9) is held and not written while stall=1.
3. From count=8: deq_count=2, fetch_valid=1 -> next count=6, out_pc0=2; the following cycle has stall=0, pair 8/9 is written, deq_count=2, count stays 6.
4. Steady state, enqueue every cycle with deq_count=2 for 20 cycles -> dequeued PCs follow 0,1,...,15,0,1,... with no gaps or duplicates across pointer and PC wrap.
5. count=1, deq_count=2, fetch_valid=0 -> count=0, out_valid0=0, out_pc0=0; then deq_count=3 at count=4 -> count=2.
6. count=5, flush=1 with fetch_valid=1 and deq_count=2 -> count=0, both valids 0 next cycle; separately, reset asserted at count=6 -> count=0, stall=0 next cycle.
